// File: rtl/cond_unit_banked_if.sv
// Decode-to-memory predication bus for cond_unit_banked.
// Statistics signals exist only when COND_STATS_EN is defined.
interface cond_unit_banked_if #(
  parameter int CTXW = 2
`ifdef COND_STATS_EN
  , parameter int CNTW = 16
`endif
);
  logic            valid_in;
  logic            stall;
  logic            flush;
  logic [CTXW-1:0] ctx_id;
  logic [3:0]      Cond;
  logic [3:0]      ALUFlags;
  logic [1:0]      FlagW;
  logic            PCS;
  logic            RegW;
  logic            MemW;
  logic            NoWrite;
  logic            CondEx;
  logic [3:0]      Flags;
  logic            PCSrc;
  logic            RegWrite;
  logic            MemWrite;
  logic            valid_out;
`ifdef COND_STATS_EN
  logic            stats_clr;
  logic [CNTW-1:0] exec_cnt;
  logic [CNTW-1:0] skip_cnt;

  modport master (
    output valid_in, stall, flush, ctx_id, Cond, ALUFlags, FlagW,
           PCS, RegW, MemW, NoWrite, stats_clr,
    input  CondEx, Flags, PCSrc, RegWrite, MemWrite, valid_out,
           exec_cnt, skip_cnt
  );
  modport slave (
    input  valid_in, stall, flush, ctx_id, Cond, ALUFlags, FlagW,
           PCS, RegW, MemW, NoWrite, stats_clr,
    output CondEx, Flags, PCSrc, RegWrite, MemWrite, valid_out,
           exec_cnt, skip_cnt
  );
`else
  modport master (
    output valid_in, stall, flush, ctx_id, Cond, ALUFlags, FlagW,
           PCS, RegW, MemW, NoWrite,
    input  CondEx, Flags, PCSrc, RegWrite, MemWrite, valid_out
  );
  modport slave (
    input  valid_in, stall, flush, ctx_id, Cond, ALUFlags, FlagW,
           PCS, RegW, MemW, NoWrite,
    output CondEx, Flags, PCSrc, RegWrite, MemWrite, valid_out
  );
`endif
endinterface

// File: rtl/cond_unit_banked.sv
// Banked ARM condition evaluator with stall/flush and branch-shadow kill.
// Define COND_STATS_EN to add saturating executed/skipped instruction counters.
module cond_unit_banked #(
  parameter int NCTX      = 4,
  parameter int CTXW      = (NCTX > 1) ? $clog2(NCTX) : 1,
  parameter int BR_SHADOW = 2
`ifdef COND_STATS_EN
  , parameter int CNTW    = 16
`endif
) (
  input logic                clk,
  input logic                reset,
  cond_unit_banked_if.slave  bus
);
  localparam int SHW = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;

  logic [CTXW-1:0] bank_sel;
  logic [3:0]      bank_rd [NCTX];
  logic [3:0]      flags_rd;
  logic            cond_ex;
  logic            kill;
  logic            accept;
  logic            take;

  logic           valid_q, valid_d;
  logic           pcsrc_q, pcsrc_d;
  logic           regwrite_q, regwrite_d;
  logic           memwrite_q, memwrite_d;
  logic [SHW-1:0] shadow_q, shadow_d;

  // A single bank ignores ctx_id entirely.
  assign bank_sel = (NCTX == 1) ? '0 : bus.ctx_id;

  always_comb begin
    flags_rd = '0;
    for (int i = 0; i < NCTX; i++) begin
      if (bank_sel == CTXW'(i)) flags_rd = bank_rd[i];
    end
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_rd;
    cond_ex = 1'b0;
    case (bus.Cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign kill   = (shadow_q != '0);
  assign accept = bus.valid_in & ~bus.stall & ~bus.flush & ~kill;
  assign take   = accept & cond_ex;

  // Flag banks: only the selected bank is written, and only by an executing instruction.
  for (genvar gi = 0; gi < NCTX; gi++) begin : g_bank
    logic [3:0] bank_q, bank_d;
    logic       hit;

    assign hit = take & (bank_sel == CTXW'(gi));

    always_comb begin
      bank_d = bank_q;
      if (hit && bus.FlagW[1]) bank_d[3:2] = bus.ALUFlags[3:2];
      if (hit && bus.FlagW[0]) bank_d[1:0] = bus.ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) bank_q <= 4'b0000;
      else        bank_q <= bank_d;
    end

    assign bank_rd[gi] = bank_q;
  end

  always_comb begin
    valid_d    = valid_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    shadow_d   = shadow_q;
    if (bus.flush) begin
      valid_d    = 1'b0;
      pcsrc_d    = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      shadow_d   = '0;
    end else if (!bus.stall) begin
      valid_d    = accept;
      pcsrc_d    = take & bus.PCS;
      regwrite_d = take & bus.RegW & ~bus.NoWrite;
      memwrite_d = take & bus.MemW;
      // Shadow is consumed by instruction slots, not by idle cycles.
      if (take && bus.PCS)             shadow_d = SHW'(BR_SHADOW);
      else if (bus.valid_in && kill)   shadow_d = shadow_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      shadow_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      shadow_q   <= shadow_d;
    end
  end

  assign bus.CondEx    = cond_ex;
  assign bus.Flags     = flags_rd;
  assign bus.PCSrc     = pcsrc_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.MemWrite  = memwrite_q;
  assign bus.valid_out = valid_q;

`ifdef COND_STATS_EN
  logic [CNTW-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNTW-1:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (bus.stats_clr) begin
      exec_cnt_d = '0;
      skip_cnt_d = '0;
    end else begin
      if (take && exec_cnt_q != '1)                 exec_cnt_d = exec_cnt_q + CNTW'(1);
      if (accept && !cond_ex && skip_cnt_q != '1)   skip_cnt_d = skip_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign bus.exec_cnt = exec_cnt_q;
  assign bus.skip_cnt = skip_cnt_q;
`endif
endmodule

// File: doc/cond_unit_banked.md
Name: cond_unit_banked

Overview:
- Next-generation predication unit for the pipelined processor, sitting between decode/execute and the memory stage.
- Evaluates the 4-bit ARM condition field against one of NCTX independent NZCV flag banks, selected per instruction by context ID.
- Gates register, memory and PC writes, and registers the gated controls into the M stage.
- Adds stall/flush handling and a branch-shadow kill counter that drops the BR_SHADOW instructions following a taken branch.

Parameters:
NCTX, 4, number of flag banks/hardware contexts (>=1)
CTXW, $clog2(NCTX) (min 1), width of ctx_id
BR_SHADOW, 2, instructions killed after a taken branch (0 disables)
CNTW, 16, statistics counter width (only with COND_STATS_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
valid_in  in  1  instruction present this cycle
stall  in  1  hold all state and outputs
flush  in  1  discard current and registered instruction
ctx_id  in  CTXW  flag bank select
Cond  in  4  condition field
ALUFlags  in  4  {N,Z,C,V} from ALU
FlagW  in  2  [1]=write N,Z; [0]=write C,V
PCS, RegW, MemW  in  1 each  ungated decode controls
NoWrite  in  1  compare op: suppress RegWrite
CondEx  out  1  combinational condition result, current cycle
Flags  out  4  combinational read of bank[ctx_id]
PCSrc, RegWrite, MemWrite  out  1 each  registered gated controls
valid_out  out  1  registered: M-stage instruction valid

Behaviour:
- Reset (reset=0, async): all banks 4'b0000; PCSrc, RegWrite, MemWrite, valid_out = 0; shadow counter = 0. Takes effect immediately, including mid-shadow or mid-stall.
- Condition decode on bank[ctx_id] {N,Z,C,V}:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- kill = (shadow counter != 0).
- accept = valid_in & !stall & !flush & !kill.
- CondEx output: raw decode result, not qualified by accept.
- Flag write, at the clock edge, only when accept & CondEx:
  - FlagW[1] writes bank[ctx_id][3:2] from ALUFlags[3:2].
  - FlagW[0] writes bank[ctx_id][1:0] from ALUFlags[1:0].
  - Other banks are never touched.
- Latency: the instruction in cycle t sees its gated controls at t+1. Flags written at t are visible to an instruction at t+1 (same ctx); no same-cycle bypass.
- Output register, priority flush > stall > normal:
  - flush: all registered outputs 0, shadow counter cleared.
  - stall: all registers hold, counter holds.
  - Otherwise:
    - valid_out <= accept
    - PCSrc <= accept&CondEx&PCS
    - RegWrite <= accept&CondEx&RegW&!NoWrite
    - MemWrite <= accept&CondEx&MemW
- Shadow counter, when not stalled/flushed:
  - Loads BR_SHADOW when accept&CondEx&PCS.
  - Otherwise decrements by 1 on each valid_in cycle while nonzero. Killed instructions produce valid_out=0 and no flag write.
  - Cycles without valid_in do not decrement.
- Taken branch while counter nonzero: impossible, since the branch is itself killed.
- NCTX=1: ctx_id ignored, single bank.

Optional Feature:
- Macro COND_STATS_EN.
- When defined:
  - Adds outputs exec_cnt[CNTW] and skip_cnt[CNTW].
  - Adds input stats_clr, synchronous clear, priority over increment.
  - exec_cnt increments on accept&CondEx; skip_cnt increments on accept&!CondEx.
  - Both saturate at all-ones and reset to 0.
  - Killed and flushed instructions are not counted.
- When undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: drive reset=0 mid-operation with bank1=4'b1111 → all banks 0, outputs 0 immediately. Release, then Cond=0 (EQ), ctx 1 → CondEx=0.
- Bank isolation:
  - ctx0: FlagW=2'b11, ALUFlags=4'b0100 (Z).
  - Next cycle ctx1 Cond=0 → CondEx=0; ctx0 Cond=0 → CondEx=1.
  - RegW=1 → RegWrite=1 at t+1.
- Partial write:
  - bank0=4'b0000; write FlagW=2'b01, ALUFlags=4'b1111 → bank0=4'b0011.
  - Cond=8 (HI) → 1; Cond=A (GE) → 0, since N=0 and V=1.
- Shadow, BR_SHADOW=2:
  - Taken branch (Cond=E, PCS=1) → PCSrc=1 at t+1.
  - Next two valid instructions with RegW=1, FlagW=2'b11 → valid_out=0, RegWrite=0, flags unchanged.
  - Third instruction executes.
  - Idle cycles between them do not consume shadow.
- Stall/flush:
  - Stall 3 cycles after an accepted MemW instruction → MemWrite holds 1, no flag change.
  - flush together with stall → outputs 0, shadow cleared.
- Cond=F and NoWrite:
  - Cond=F, RegW=MemW=PCS=1, FlagW=2'b11 → all gated outputs 0, flags unchanged.
  - Cond=E, RegW=1, NoWrite=1, FlagW=2'b11 → RegWrite=0, flags updated.
